// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared types for the CPU memory-port arbiter: FSM state, request owner
// and the captured downstream request bundle.
package arb_types;

  // Data/address width carried by the request bundle; the arbiter's WIDTH
  // parameter must match because the packed struct is sized here.
  localparam int ARB_WIDTH = 32;
  localparam int ARB_BE_W  = ARB_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

  typedef struct packed {
    logic                 read;
    logic                 write;
    logic [ARB_BE_W-1:0]  byte_enable;
    logic [ARB_WIDTH-1:0] address;
    logic [ARB_WIDTH-1:0] wdata;
  } mem_req_t;

  // Build a request bundle; read&write together is treated as a write.
  function automatic mem_req_t make_req(input logic                 read,
                                        input logic                 write,
                                        input logic [ARB_BE_W-1:0]  be,
                                        input logic [ARB_WIDTH-1:0] address,
                                        input logic [ARB_WIDTH-1:0] wdata);
    mem_req_t r;
    r.read        = read & ~write;
    r.write       = write;
    r.byte_enable = be;
    r.address     = address;
    r.wdata       = wdata;
    return r;
  endfunction

endpackage

// File: rtl/cpu_mem_arbiter_mem_req_reg.sv
// Loadable holding register for the granted request bundle and its owner.
// Cleared synchronously by rst so the downstream port reads 0 after reset.
module mem_req_reg
  import arb_types::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  mem_req_t   req_in,
  input  arb_owner_t owner_in,
  output mem_req_t   req_out,
  output arb_owner_t owner_out
);

  mem_req_t   req_d,   req_q;
  arb_owner_t owner_d, owner_q;

  // Next value: take the new bundle on load, otherwise hold.
  always_comb begin
    req_d   = req_q;
    owner_d = owner_q;
    if (load) begin
      req_d   = req_in;
      owner_d = owner_in;
    end
  end

  // Bundle register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q   <= '0;
      owner_q <= OWN_I;
    end else begin
      req_q   <= req_d;
      owner_q <= owner_d;
    end
  end

  assign req_out   = req_q;
  assign owner_out = owner_q;

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Arbiter between the CPU fetch port (i_mem_*) and the LSQ port (d_mem_*)
// onto one downstream memory port using the same read/write/resp protocol.
// One request is in flight at a time: IDLE grants, BUSY drives the captured
// bundle downstream until mem_resp, RESP pulses the owner's resp once.
//
// Handshake: a requester raises read or write and holds the whole bundle
// until it sees its single-cycle resp; it may change the request in the
// cycle after resp. Downstream mem_read/mem_write likewise stay high until
// mem_resp, and are dropped in the cycle after it.
//
// Build option: define ARB_RR_EN to alternate grants on contention (the
// port not granted most recently wins); otherwise d has fixed priority.
module cpu_mem_arbiter
  import arb_types::*;
#(
  parameter int WIDTH = ARB_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_mem_read,
  input  logic               i_mem_write,
  input  logic [WIDTH/8-1:0] i_mem_byte_enable,
  input  logic [WIDTH-1:0]   i_mem_address,
  input  logic [WIDTH-1:0]   i_mem_wdata,
  output logic               i_mem_resp,
  output logic [WIDTH-1:0]   i_mem_rdata,
  input  logic               d_mem_read,
  input  logic               d_mem_write,
  input  logic [WIDTH/8-1:0] d_mem_byte_enable,
  input  logic [WIDTH-1:0]   d_mem_address,
  input  logic [WIDTH-1:0]   d_mem_wdata,
  output logic               d_mem_resp,
  output logic [WIDTH-1:0]   d_mem_rdata,
  output logic               mem_read,
  output logic               mem_write,
  output logic [WIDTH/8-1:0] mem_byte_enable,
  output logic [WIDTH-1:0]   mem_address,
  output logic [WIDTH-1:0]   mem_wdata,
  input  logic               mem_resp,
  input  logic [WIDTH-1:0]   mem_rdata
);

  arb_state_t       state_d, state_q;
  logic [WIDTH-1:0] i_rdata_d, i_rdata_q;
  logic [WIDTH-1:0] d_rdata_d, d_rdata_q;

  logic       i_req, d_req;
  logic       load;
  arb_owner_t owner_sel;
  mem_req_t   req_sel;
  mem_req_t   req_q;
  arb_owner_t owner_q;
  logic       busy;

`ifdef ARB_RR_EN
  arb_owner_t last_owner_d, last_owner_q;
`endif

  assign i_req = i_mem_read | i_mem_write;
  assign d_req = d_mem_read | d_mem_write;

  // Next-state, grant selection and read-data capture.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    owner_sel = OWN_I;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
`ifdef ARB_RR_EN
    last_owner_d = last_owner_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          load    = 1'b1;
          state_d = BUSY;
          if (i_req && d_req) begin
`ifdef ARB_RR_EN
            owner_sel = (last_owner_q == OWN_I) ? OWN_D : OWN_I;
`else
            owner_sel = OWN_D;
`endif
          end else begin
            owner_sel = d_req ? OWN_D : OWN_I;
          end
`ifdef ARB_RR_EN
          last_owner_d = owner_sel;
`endif
        end
      end
      BUSY: begin
        if (mem_resp) begin
          state_d = RESP;
          // Only reads update the owner's rdata; writes leave it untouched.
          if (req_q.read) begin
            if (owner_q == OWN_I) i_rdata_d = mem_rdata;
            else                  d_rdata_d = mem_rdata;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bundle of the port being granted this cycle.
  always_comb begin
    req_sel = make_req(i_mem_read, i_mem_write, i_mem_byte_enable,
                       i_mem_address, i_mem_wdata);
    if (owner_sel == OWN_D) begin
      req_sel = make_req(d_mem_read, d_mem_write, d_mem_byte_enable,
                         d_mem_address, d_mem_wdata);
    end
  end

  // State and read-data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

`ifdef ARB_RR_EN
  // Most recent grant; reset to i so the first contended grant goes to d.
  always_ff @(posedge clk) begin
    if (rst) last_owner_q <= OWN_I;
    else     last_owner_q <= last_owner_d;
  end
`endif

  mem_req_reg u_req_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .req_in    (req_sel),
    .owner_in  (owner_sel),
    .req_out   (req_q),
    .owner_out (owner_q)
  );

  // Downstream request only while BUSY, so it drops the cycle after mem_resp.
  assign busy            = (state_q == BUSY);
  assign mem_read        = busy & req_q.read;
  assign mem_write       = busy & req_q.write;
  assign mem_byte_enable = busy ? req_q.byte_enable : '0;
  assign mem_address     = busy ? req_q.address     : '0;
  assign mem_wdata       = busy ? req_q.wdata       : '0;

  assign i_mem_resp  = (state_q == RESP) && (owner_q == OWN_I);
  assign d_mem_resp  = (state_q == RESP) && (owner_q == OWN_D);
  assign i_mem_rdata = i_rdata_q;
  assign d_mem_rdata = d_rdata_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Self-checking bench for cpu_mem_arbiter: requester driver tasks, a
// downstream memory model, and per-port expected-rdata queues checked on
// every resp pulse. Honours ARB_RR_EN for the contention order checks.
module tb_cpu_mem_arbiter;
  import arb_types::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_mem_read, i_mem_write, d_mem_read, d_mem_write;
  logic [3:0]   i_mem_byte_enable, d_mem_byte_enable, mem_byte_enable;
  logic [W-1:0] i_mem_address, i_mem_wdata, d_mem_address, d_mem_wdata;
  logic         i_mem_resp, d_mem_resp;
  logic [W-1:0] i_mem_rdata, d_mem_rdata;
  logic         mem_read, mem_write;
  logic [W-1:0] mem_address, mem_wdata;
  logic         mem_resp;
  logic [W-1:0] mem_rdata;

  int n_cmp = 0;
  int n_fail = 0;
  int i_resp_cnt = 0;
  int d_resp_cnt = 0;
  int dn_cnt = 0;

  // memory model controls
  bit mem_auto = 1'b1;
  bit mem_kick = 1'b0;
  int mem_lat  = 0;

  logic [W-1:0] exp_i_q[$];
  logic [W-1:0] exp_d_q[$];
  logic [W-1:0] exp_i_rdata = '0;
  logic [W-1:0] exp_d_rdata = '0;

  logic [W-1:0] dn_addr_q[$];
  logic [W-1:0] dn_wdata_q[$];
  logic [3:0]   dn_be_q[$];
  bit           dn_wr_q[$];

  cpu_mem_arbiter #(.WIDTH(W)) dut (
    .clk               (clk),
    .rst               (rst),
    .i_mem_read        (i_mem_read),
    .i_mem_write       (i_mem_write),
    .i_mem_byte_enable (i_mem_byte_enable),
    .i_mem_address     (i_mem_address),
    .i_mem_wdata       (i_mem_wdata),
    .i_mem_resp        (i_mem_resp),
    .i_mem_rdata       (i_mem_rdata),
    .d_mem_read        (d_mem_read),
    .d_mem_write       (d_mem_write),
    .d_mem_byte_enable (d_mem_byte_enable),
    .d_mem_address     (d_mem_address),
    .d_mem_wdata       (d_mem_wdata),
    .d_mem_resp        (d_mem_resp),
    .d_mem_rdata       (d_mem_rdata),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .mem_byte_enable   (mem_byte_enable),
    .mem_address       (mem_address),
    .mem_wdata         (mem_wdata),
    .mem_resp          (mem_resp),
    .mem_rdata         (mem_rdata)
  );

  // clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // read data the downstream memory returns for an address
  function automatic logic [W-1:0] model_rd(input logic [W-1:0] a);
    if (a == 32'h60) return 32'h0000_0013;
    return {a[15:0], ~a[15:0]};
  endfunction

  // downstream memory model: logs each request, answers after a latency
  initial begin
    mem_resp  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if ((mem_auto && (mem_read || mem_write)) || mem_kick) begin
        int lat;
        logic [W-1:0] rd;
        rd = $urandom;
        if (!mem_kick) begin
          dn_cnt++;
          dn_addr_q.push_back(mem_address);
          dn_wdata_q.push_back(mem_wdata);
          dn_be_q.push_back(mem_byte_enable);
          dn_wr_q.push_back(mem_write);
          if (mem_read) rd = model_rd(mem_address);
        end
        lat = (mem_lat > 0) ? mem_lat : int'($urandom_range(1, 5));
        for (int k = 0; k < lat - 1; k++) @(posedge clk);
        @(posedge clk); #1;
        mem_resp  = 1'b1;
        mem_rdata = rd;
        @(posedge clk); #1;
        mem_resp  = 1'b0;
        mem_rdata = $urandom;
      end
    end
  end

  // scoreboard: each resp pulse pops that port's expected rdata
  initial begin
    forever begin
      logic [W-1:0] e;
      @(negedge clk);
      if (i_mem_resp && d_mem_resp) begin
        n_cmp++; n_fail++;
        $display("FAIL dual_resp: both resp high at %0t, required at most one", $time);
      end
      if (i_mem_resp) begin
        i_resp_cnt++;
        n_cmp++;
        if (exp_i_q.size() == 0) begin
          n_fail++;
          $display("FAIL i_resp_unexpected: i_mem_resp with rdata %h at %0t, required no resp", i_mem_rdata, $time);
        end else begin
          e = exp_i_q.pop_front();
          if (i_mem_rdata !== e) begin
            n_fail++;
            $display("FAIL i_rdata: got %h required %h at %0t", i_mem_rdata, e, $time);
          end
        end
      end
      if (d_mem_resp) begin
        d_resp_cnt++;
        n_cmp++;
        if (exp_d_q.size() == 0) begin
          n_fail++;
          $display("FAIL d_resp_unexpected: d_mem_resp with rdata %h at %0t, required no resp", d_mem_rdata, $time);
        end else begin
          e = exp_d_q.pop_front();
          if (d_mem_rdata !== e) begin
            n_fail++;
            $display("FAIL d_rdata: got %h required %h at %0t", d_mem_rdata, e, $time);
          end
        end
      end
    end
  end

  task automatic clear_log();
    dn_addr_q.delete(); dn_wdata_q.delete(); dn_be_q.delete(); dn_wr_q.delete();
  endtask

  // requester driver: raise a request, hold until resp, then drop or hand over
  task automatic drive_req(input bit is_d, input bit wr, input logic [W-1:0] addr,
                           input logic [W-1:0] wdata, input logic [3:0] be,
                           input bit keep);
    int t;
    if (is_d) begin
      if (!wr) exp_d_rdata = model_rd(addr);
      exp_d_q.push_back(exp_d_rdata);
      d_mem_read = !wr; d_mem_write = wr; d_mem_address = addr;
      d_mem_wdata = wdata; d_mem_byte_enable = be;
    end else begin
      if (!wr) exp_i_rdata = model_rd(addr);
      exp_i_q.push_back(exp_i_rdata);
      i_mem_read = !wr; i_mem_write = wr; i_mem_address = addr;
      i_mem_wdata = wdata; i_mem_byte_enable = be;
    end
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(is_d ? d_mem_resp : i_mem_resp) && t < 300);
    n_cmp++;
    if (t >= 300) begin
      n_fail++;
      $display("FAIL req_timeout: port %s addr %h no resp after %0d cycles, required resp", is_d ? "d" : "i", addr, t);
    end
    @(posedge clk); #1;
    if (!keep) begin
      if (is_d) begin d_mem_read = 1'b0; d_mem_write = 1'b0; end
      else      begin i_mem_read = 1'b0; i_mem_write = 1'b0; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_mem_read = 0; i_mem_write = 0; i_mem_byte_enable = 0; i_mem_address = 0; i_mem_wdata = 0;
    d_mem_read = 0; d_mem_write = 0; d_mem_byte_enable = 0; d_mem_address = 0; d_mem_wdata = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata, i_mem_resp,
         d_mem_resp, i_mem_rdata, d_mem_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: mem_read=%b mem_write=%b addr=%h i_rdata=%h d_rdata=%h, required all 0",
               mem_read, mem_write, mem_address, i_mem_rdata, d_mem_rdata);
    end
    n_cmp++;
    if (dut.state_q !== IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %0d required IDLE", dut.state_q);
    end
  endtask

  task automatic test_lone_fetch();
    int i0, d0;
    i0 = i_resp_cnt; d0 = d_resp_cnt;
    mem_lat = 4;
    clear_log();
    @(posedge clk); #1;
    fork
      drive_req(1'b0, 1'b0, 32'h60, 32'h0, 4'hF, 1'b0);
      begin
        @(negedge clk);
        n_cmp++;
        if (mem_read !== 1'b0) begin
          n_fail++;
          $display("FAIL fetch_latency_early: mem_read=%b in request cycle, required 0", mem_read);
        end
        @(negedge clk);
        n_cmp++;
        if (mem_read !== 1'b1 || mem_address !== 32'h60) begin
          n_fail++;
          $display("FAIL fetch_latency: mem_read=%b addr=%h one cycle after request, required 1 / 00000060", mem_read, mem_address);
        end
      end
    join
    repeat (3) @(negedge clk);
    n_cmp++;
    if (i_resp_cnt - i0 !== 1 || d_resp_cnt - d0 !== 0) begin
      n_fail++;
      $display("FAIL fetch_resp_count: i=%0d d=%0d, required 1 / 0", i_resp_cnt - i0, d_resp_cnt - d0);
    end
    n_cmp++;
    if (i_mem_rdata !== 32'h0000_0013) begin
      n_fail++;
      $display("FAIL fetch_rdata_hold: got %h required 00000013", i_mem_rdata);
    end
  endtask

  task automatic test_contention();
    mem_lat = 2;
    clear_log();
    @(posedge clk); #1;
    fork
      drive_req(1'b0, 1'b0, 32'h100, 32'h0, 4'hF, 1'b0);
      drive_req(1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF, 4'hF, 1'b0);
    join
    n_cmp++;
    if (dn_addr_q.size() != 2) begin
      n_fail++;
      $display("FAIL contention_count: %0d downstream requests, required 2", dn_addr_q.size());
    end else begin
      if (dn_addr_q[0] !== 32'h2000 || dn_wr_q[0] !== 1'b1 || dn_wdata_q[0] !== 32'hDEAD_BEEF || dn_be_q[0] !== 4'hF) begin
        n_fail++;
        $display("FAIL contention_first: addr=%h wr=%b wdata=%h be=%h, required 00002000 1 deadbeef f",
                 dn_addr_q[0], dn_wr_q[0], dn_wdata_q[0], dn_be_q[0]);
      end
      n_cmp++;
      if (dn_addr_q[1] !== 32'h100 || dn_wr_q[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL contention_second: addr=%h wr=%b, required 00000100 0", dn_addr_q[1], dn_wr_q[1]);
      end
    end
  endtask

  task automatic test_round_robin();
    bit exp_d[4];
`ifdef ARB_RR_EN
    exp_d = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_d = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    mem_lat = 2;
    clear_log();
    @(posedge clk); #1;
    fork
      for (int k = 0; k < 4; k++)
        drive_req(1'b1, 1'b0, 32'h2000 + 32'(k * 4), 32'h0, 4'hF, k < 3);
      for (int k = 0; k < 4; k++)
        drive_req(1'b0, 1'b0, 32'h100 + 32'(k * 4), 32'h0, 4'hF, k < 3);
    join
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (dn_addr_q.size() <= k) begin
        n_fail++;
        $display("FAIL rr_order_%0d: missing grant, required %s", k, exp_d[k] ? "d" : "i");
      end else if ((dn_addr_q[k] >= 32'h1000) !== exp_d[k]) begin
        n_fail++;
        $display("FAIL rr_order_%0d: granted addr %h, required port %s", k, dn_addr_q[k], exp_d[k] ? "d" : "i");
      end
    end
  endtask

  task automatic test_held_request();
    int i0, n0;
    mem_lat = 1;
    i0 = i_resp_cnt; n0 = dn_cnt;
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, 32'h140, 32'h0, 4'h3, 1'b0);
    repeat (6) @(negedge clk);
    n_cmp++;
    if (dn_cnt - n0 !== 1 || i_resp_cnt - i0 !== 1) begin
      n_fail++;
      $display("FAIL held_single: downstream=%0d resp=%0d, required 1 / 1", dn_cnt - n0, i_resp_cnt - i0);
    end
  endtask

  task automatic test_back_to_back();
    mem_lat = 0;
    for (int k = 0; k < 6; k++) begin
      bit is_d, wr;
      logic [W-1:0] a;
      is_d = 1'($urandom_range(0, 1));
      wr   = 1'($urandom_range(0, 1));
      a    = (is_d ? 32'h2000 : 32'h100) + 32'($urandom_range(0, 63) * 4);
      clear_log();
      drive_req(is_d, wr, a, $urandom, 4'($urandom_range(0, 15)), 1'b0);
      n_cmp++;
      if (dn_addr_q.size() != 1 || dn_addr_q[0] !== a || dn_wr_q[0] !== wr) begin
        n_fail++;
        $display("FAIL b2b_%0d: %0d requests first addr %h wr %b, required 1 request addr %h wr %b",
                 k, dn_addr_q.size(), dn_addr_q.size() ? dn_addr_q[0] : 32'hx, dn_wr_q.size() ? dn_wr_q[0] : 1'bx, a, wr);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    int i0, d0;
    mem_auto = 1'b0;
    @(posedge clk); #1;
    i_mem_read = 1'b1; i_mem_address = 32'h80; i_mem_byte_enable = 4'hF;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (mem_read !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_busy: mem_read=%b before reset, required 1", mem_read);
    end
    @(posedge clk); #1;
    rst = 1'b1; i_mem_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata, i_mem_resp,
         d_mem_resp, i_mem_rdata, d_mem_rdata} !== '0) begin
      n_fail++;
      $display("FAIL midop_outputs: mem_read=%b addr=%h i_resp=%b i_rdata=%h d_rdata=%h, required all 0",
               mem_read, mem_address, i_mem_resp, i_mem_rdata, d_mem_rdata);
    end
    n_cmp++;
    if (dut.state_q !== IDLE) begin
      n_fail++;
      $display("FAIL midop_state: got %0d required IDLE", dut.state_q);
    end
    exp_i_rdata = '0; exp_d_rdata = '0;
    i0 = i_resp_cnt; d0 = d_resp_cnt;
    mem_lat = 1;
    @(posedge clk); #1;
    mem_kick = 1'b1;
    @(negedge clk); #1;
    mem_kick = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (i_resp_cnt != i0 || d_resp_cnt != d0) begin
      n_fail++;
      $display("FAIL midop_stray_resp: i=%0d d=%0d resp after stray mem_resp, required 0 / 0", i_resp_cnt - i0, d_resp_cnt - d0);
    end
    mem_auto = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_contention();
    test_round_robin();
    test_held_request();
    test_back_to_back();
    test_reset_mid_op();
    repeat (4) @(negedge clk);
    n_cmp++;
    if (exp_i_q.size() != 0 || exp_d_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_expect: i=%0d d=%0d outstanding, required 0 / 0", exp_i_q.size(), exp_d_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
